fp_add_align_prep: RTL and testbench

// Operand-alignment front end of the shared FP32 / bf16x2 adder; sits directly upstream of barrel_shifter.
// Per lane: compares magnitudes, swaps so the larger operand is "big", computes the saturated exponent difference.

---
 rtl/fp_add_align_prep.sv | 259 +++++++++++++++++++++++++
 tb/tb_fp_add_align_prep.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_align_prep.sv
// Operand-alignment front end for the shared FP32 / bf16x2 adder.
// Two-stage valid/ready pipe: compare/swap/exponent-difference, then shifter-format packing.

package fp_add_align_prep_pkg;
  typedef enum logic {
    FP32 = 1'b0,
    FP16 = 1'b1
  } fp_fmt_e;
endpackage

module fp_add_align_prep
  import fp_add_align_prep_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp_fmt_e          fmt,
  input  logic             op_sub,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output fp_fmt_e          out_fmt,
  output logic [23:0]      x_small,
  output logic [7:0]       shamt,
  output logic [23:0]      big_frac,
  output logic [15:0]      big_exp,
  output logic [1:0]       big_sign,
  output logic [1:0]       eff_sub,
  output logic [1:0]       swapped,
  output logic [1:0]       special,
  output logic [TAG_W-1:0] tag_out
);

  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s1_load, s2_load;

  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  // ---------------- stage 1 combinational: compare and exponent difference
  logic       a_ge_32;
  logic [7:0] d_32;
  logic       sb_32;

  assign a_ge_32 = a[30:0] >= b[30:0];
  assign d_32    = a_ge_32 ? (a[30:23] - b[30:23]) : (b[30:23] - a[30:23]);
  assign sb_32   = b[31] ^ op_sub;

  logic [1:0]      h_ge;
  logic [1:0]      h_eff;
  logic [1:0]      h_bsign;
  logic [1:0]      h_spec;
  logic [1:0][7:0] h_d;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane_cmp
      logic [15:0] ha;
      logic [15:0] hb;
      logic        hsb;
      logic        ge;
      assign ha          = a[16*gi +: 16];
      assign hb          = b[16*gi +: 16];
      assign hsb         = hb[15] ^ op_sub;
      assign ge          = ha[14:0] >= hb[14:0];
      assign h_ge[gi]    = ge;
      assign h_d[gi]     = ge ? (ha[14:7] - hb[14:7]) : (hb[14:7] - ha[14:7]);
      assign h_eff[gi]   = ha[15] ^ hsb;
      assign h_bsign[gi] = ge ? ha[15] : hsb;
      assign h_spec[gi]  = (ha[14:7] == 8'hFF) || (hb[14:7] == 8'hFF);
    end
  endgenerate

  // ---------------- stage 1 registers
  logic [31:0]      s1_a_q, s1_a_d;
  logic [31:0]      s1_b_q, s1_b_d;
  fp_fmt_e          s1_fmt_q, s1_fmt_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [1:0]       s1_swap_q, s1_swap_d;
  logic [1:0][7:0]  s1_d_q, s1_d_d;
  logic [1:0]       s1_eff_q, s1_eff_d;
  logic [1:0]       s1_bsign_q, s1_bsign_d;
  logic [1:0]       s1_spec_q, s1_spec_d;

  always_comb begin
    s1_valid_d = s1_load ? in_valid : s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_fmt_d   = s1_fmt_q;
    s1_tag_d   = s1_tag_q;
    s1_swap_d  = s1_swap_q;
    s1_d_d     = s1_d_q;
    s1_eff_d   = s1_eff_q;
    s1_bsign_d = s1_bsign_q;
    s1_spec_d  = s1_spec_q;
    if (s1_load && in_valid) begin
      s1_a_d   = a;
      s1_b_d   = b;
      s1_fmt_d = fmt;
      s1_tag_d = tag;
      if (fmt == FP16) begin
        s1_swap_d  = ~h_ge;
        s1_d_d     = h_d;
        s1_eff_d   = h_eff;
        s1_bsign_d = h_bsign;
        s1_spec_d  = h_spec;
      end else begin
        // Lane 1 bits are meaningless for a single fp32 op and are held at 0.
        s1_swap_d  = {1'b0, ~a_ge_32};
        s1_d_d     = {8'h00, d_32};
        s1_eff_d   = {1'b0, a[31] ^ sb_32};
        s1_bsign_d = {1'b0, a_ge_32 ? a[31] : sb_32};
        s1_spec_d  = {1'b0, (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF)};
      end
    end
  end

  // ---------------- stage 2 combinational: operand select, denormal flush, packing
  logic [31:0] big_32, small_32;
  logic [23:0] fb_32, fs_32;
  logic [4:0]  sat_32;

  assign big_32   = s1_swap_q[0] ? s1_b_q : s1_a_q;
  assign small_32 = s1_swap_q[0] ? s1_a_q : s1_b_q;
  assign fb_32    = (big_32[30:23] == 8'h00) ? 24'h000000 : {1'b1, big_32[22:0]};
  assign fs_32    = (small_32[30:23] == 8'h00) ? 24'h000000 : {1'b1, small_32[22:0]};
  assign sat_32   = (s1_d_q[0][7:5] != 3'b000) ? 5'd31 : s1_d_q[0][4:0];

  logic [1:0][7:0] fb_16;
  logic [1:0][7:0] fs_16;
  logic [1:0][7:0] eb_16;
  logic [1:0][3:0] sat_16;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane_pack
      logic [15:0] hbig;
      logic [15:0] hsmall;
      assign hbig        = s1_swap_q[gi] ? s1_b_q[16*gi +: 16] : s1_a_q[16*gi +: 16];
      assign hsmall      = s1_swap_q[gi] ? s1_a_q[16*gi +: 16] : s1_b_q[16*gi +: 16];
      assign fb_16[gi]   = (hbig[14:7] == 8'h00) ? 8'h00 : {1'b1, hbig[6:0]};
      assign fs_16[gi]   = (hsmall[14:7] == 8'h00) ? 8'h00 : {1'b1, hsmall[6:0]};
      assign eb_16[gi]   = hbig[14:7];
      assign sat_16[gi]  = (s1_d_q[gi][7:4] != 4'h0) ? 4'hF : s1_d_q[gi][3:0];
    end
  endgenerate

  // ---------------- stage 2 registers (module outputs)
  fp_fmt_e          out_fmt_q, out_fmt_d;
  logic [23:0]      x_small_q, x_small_d;
  logic [7:0]       shamt_q, shamt_d;
  logic [23:0]      big_frac_q, big_frac_d;
  logic [15:0]      big_exp_q, big_exp_d;
  logic [1:0]       big_sign_q, big_sign_d;
  logic [1:0]       eff_sub_q, eff_sub_d;
  logic [1:0]       swapped_q, swapped_d;
  logic [1:0]       special_q, special_d;
  logic [TAG_W-1:0] tag_out_q, tag_out_d;

  always_comb begin
    out_valid_d = s2_load ? s1_valid_q : out_valid_q;
    out_fmt_d   = out_fmt_q;
    x_small_d   = x_small_q;
    shamt_d     = shamt_q;
    big_frac_d  = big_frac_q;
    big_exp_d   = big_exp_q;
    big_sign_d  = big_sign_q;
    eff_sub_d   = eff_sub_q;
    swapped_d   = swapped_q;
    special_d   = special_q;
    tag_out_d   = tag_out_q;
    if (s2_load && s1_valid_q) begin
      out_fmt_d  = s1_fmt_q;
      big_sign_d = s1_bsign_q;
      eff_sub_d  = s1_eff_q;
      swapped_d  = s1_swap_q;
      special_d  = s1_spec_q;
      tag_out_d  = s1_tag_q;
      if (s1_fmt_q == FP16) begin
        // Gap byte [15:8] separates the two lanes so the shifter cannot bleed hi into lo.
        x_small_d  = {fs_16[1], 8'h00, fs_16[0]};
        big_frac_d = {fb_16[1], 8'h00, fb_16[0]};
        shamt_d    = {sat_16[1], sat_16[0]};
        big_exp_d  = {eb_16[1], eb_16[0]};
      end else begin
        x_small_d  = fs_32;
        big_frac_d = fb_32;
        shamt_d    = {3'b000, sat_32};
        big_exp_d  = {8'h00, big_32[30:23]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_fmt_q    <= FP32;
      s1_tag_q    <= '0;
      s1_swap_q   <= '0;
      s1_d_q      <= '0;
      s1_eff_q    <= '0;
      s1_bsign_q  <= '0;
      s1_spec_q   <= '0;
      out_valid_q <= 1'b0;
      out_fmt_q   <= FP32;
      x_small_q   <= '0;
      shamt_q     <= '0;
      big_frac_q  <= '0;
      big_exp_q   <= '0;
      big_sign_q  <= '0;
      eff_sub_q   <= '0;
      swapped_q   <= '0;
      special_q   <= '0;
      tag_out_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_fmt_q    <= s1_fmt_d;
      s1_tag_q    <= s1_tag_d;
      s1_swap_q   <= s1_swap_d;
      s1_d_q      <= s1_d_d;
      s1_eff_q    <= s1_eff_d;
      s1_bsign_q  <= s1_bsign_d;
      s1_spec_q   <= s1_spec_d;
      out_valid_q <= out_valid_d;
      out_fmt_q   <= out_fmt_d;
      x_small_q   <= x_small_d;
      shamt_q     <= shamt_d;
      big_frac_q  <= big_frac_d;
      big_exp_q   <= big_exp_d;
      big_sign_q  <= big_sign_d;
      eff_sub_q   <= eff_sub_d;
      swapped_q   <= swapped_d;
      special_q   <= special_d;
      tag_out_q   <= tag_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_fmt   = out_fmt_q;
  assign x_small   = x_small_q;
  assign shamt     = shamt_q;
  assign big_frac  = big_frac_q;
  assign big_exp   = big_exp_q;
  assign big_sign  = big_sign_q;
  assign eff_sub   = eff_sub_q;
  assign swapped   = swapped_q;
  assign special   = special_q;
  assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_fp_add_align_prep.sv
// Directed + randomized bench for fp_add_align_prep with an arithmetic reference model
// and an in-order scoreboard driven by the accepted/drained handshakes.

module tb_fp_add_align_prep;
  import fp_add_align_prep_pkg::*;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  fp_fmt_e          fmt;
  logic             op_sub;
  logic [31:0]      a;
  logic [31:0]      b;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  fp_fmt_e          out_fmt;
  logic [23:0]      x_small;
  logic [7:0]       shamt;
  logic [23:0]      big_frac;
  logic [15:0]      big_exp;
  logic [1:0]       big_sign;
  logic [1:0]       eff_sub;
  logic [1:0]       swapped;
  logic [1:0]       special;
  logic [TAG_W-1:0] tag_out;

  fp_add_align_prep #(.TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fmt      (fmt),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
    .tag      (tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_fmt  (out_fmt),
    .x_small  (x_small),
    .shamt    (shamt),
    .big_frac (big_frac),
    .big_exp  (big_exp),
    .big_sign (big_sign),
    .eff_sub  (eff_sub),
    .swapped  (swapped),
    .special  (special),
    .tag_out  (tag_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fmt;
    logic [23:0] x_small;
    logic [7:0]  shamt;
    logic [23:0] big_frac;
    logic [15:0] big_exp;
    logic [1:0]  big_sign;
    logic [1:0]  eff_sub;
    logic [1:0]  swapped;
    logic [1:0]  special;
    logic [3:0]  tag;
  } res_t;

  res_t q[$];
  int   cyc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   occ = 0;
  res_t ovr;
  bit   ovr_en = 0;
  bit   lat_chk = 0;
  bit   prev_stall = 0;
  res_t prev_obs;
  bit   last_acc = 0;

  // One operand pair in one lane, from the arithmetic definition of the format.
  function automatic void lane_model(input longint sa, ea, ma, sb, eb, mb, mbits,
                                     output longint bsign, eff, swp, sp, d,
                                     output longint fbig, fsmall, ebig);
    longint hid, fa, fb;
    hid    = longint'(1) << mbits;
    fa     = (ea == 0) ? 0 : hid + ma;
    fb     = (eb == 0) ? 0 : hid + mb;
    swp    = (ea * hid + ma >= eb * hid + mb) ? 0 : 1;
    eff    = sa ^ sb;
    bsign  = swp ? sb : sa;
    ebig   = swp ? eb : ea;
    d      = swp ? eb - ea : ea - eb;
    fbig   = swp ? fb : fa;
    fsmall = swp ? fa : fb;
    sp     = (ea == 255 || eb == 255) ? 1 : 0;
  endfunction

  function automatic res_t model(input logic f, input logic sub, input logic [31:0] av,
                                 input logic [31:0] bv, input logic [3:0] t);
    res_t r;
    longint bs, ef, sw, sp, d, fbg, fsm, ebg;
    logic [15:0] ha, hb;
    r = '0;
    r.fmt = f;
    r.tag = t;
    if (!f) begin
      lane_model(av[31], av[30:23], av[22:0], bv[31] ^ sub, bv[30:23], bv[22:0], 23,
                 bs, ef, sw, sp, d, fbg, fsm, ebg);
      r.shamt       = 8'((d > 31) ? 31 : d);
      r.x_small     = 24'(fsm);
      r.big_frac    = 24'(fbg);
      r.big_exp     = 16'(ebg);
      r.big_sign[0] = bs[0];
      r.eff_sub[0]  = ef[0];
      r.swapped[0]  = sw[0];
      r.special[0]  = sp[0];
    end else begin
      for (int l = 0; l < 2; l++) begin
        ha = av[16*l +: 16];
        hb = bv[16*l +: 16];
        lane_model(ha[15], ha[14:7], ha[6:0], hb[15] ^ sub, hb[14:7], hb[6:0], 7,
                   bs, ef, sw, sp, d, fbg, fsm, ebg);
        r.x_small     = r.x_small | (24'(fsm) << (16 * l));
        r.big_frac    = r.big_frac | (24'(fbg) << (16 * l));
        r.shamt       = r.shamt | (8'((d > 15) ? 15 : d) << (4 * l));
        r.big_exp     = r.big_exp | (16'(ebg) << (8 * l));
        r.big_sign[l] = bs[0];
        r.eff_sub[l]  = ef[0];
        r.swapped[l]  = sw[0];
        r.special[l]  = sp[0];
      end
    end
    return r;
  endfunction

  function automatic res_t observe();
    res_t o;
    o.fmt      = out_fmt;
    o.x_small  = x_small;
    o.shamt    = shamt;
    o.big_frac = big_frac;
    o.big_exp  = big_exp;
    o.big_sign = big_sign;
    o.eff_sub  = eff_sub;
    o.swapped  = swapped;
    o.special  = special;
    o.tag      = tag_out;
    return o;
  endfunction

  // One clock: drive at negedge, sample 1ns later, score both handshakes.
  task automatic cycle(input bit v, input logic f, input bit s, input logic [31:0] av,
                       input logic [31:0] bv, input logic [3:0] t, input bit rdy);
    res_t obs, e;
    int   c;
    bit   fi, fo, exp_rdy;
    @(negedge clk);
    in_valid  = v;
    fmt       = fp_fmt_e'(f);
    op_sub    = s;
    a         = av;
    b         = bv;
    tag       = t;
    out_ready = rdy;
    #1;
    cyc++;
    obs = observe();
    exp_rdy = (occ < 2) || rdy;
    checks++;
    assert (in_ready === exp_rdy) else begin
      errors++;
      $error("FAIL in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_rdy);
    end
    if (occ == 0) begin
      checks++;
      assert (out_valid === 1'b0) else begin
        errors++;
        $error("FAIL empty_out_valid cyc=%0d got=%b want=0", cyc, out_valid);
      end
    end
    if (prev_stall) begin
      checks++;
      assert (out_valid === 1'b1 && obs === prev_obs) else begin
        errors++;
        $error("FAIL hold cyc=%0d got=%h want=%h", cyc, obs, prev_obs);
      end
    end
    fo = (out_valid === 1'b1) && rdy;
    fi = v && (in_ready === 1'b1);
    if (fo) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_out cyc=%0d got=%h want=none", cyc, obs);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        c = cyc_q.pop_front();
        checks++;
        assert (obs === e) else begin
          errors++;
          $error("FAIL result tag=%h got=%h want=%h", e.tag, obs, e);
        end
        $display("txn cyc=%0d tag=%h fmt=%0d x_small=%h shamt=%h big_frac=%h big_exp=%h sw=%b",
                 cyc, obs.tag, obs.fmt, obs.x_small, obs.shamt, obs.big_frac, obs.big_exp,
                 obs.swapped);
        if (lat_chk) begin
          checks++;
          assert (cyc - c == 2) else begin
            errors++;
            $error("FAIL latency tag=%h got=%0d want=2", e.tag, cyc - c);
          end
        end
        occ--;
      end
    end
    if (fi) begin
      q.push_back(ovr_en ? ovr : model(f, s, av, bv, t));
      cyc_q.push_back(cyc);
      occ++;
    end
    ovr_en     = 0;
    last_acc   = fi;
    prev_stall = (out_valid === 1'b1) && !rdy;
    prev_obs   = obs;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && occ > 0; i++) cycle(0, 1'b0, 0, 32'h0, 32'h0, 4'h0, 1);
    checks++;
    assert (occ == 0) else begin
      errors++;
      $error("FAIL drain got=%0d want=0 pending", occ);
    end
  endtask

  task automatic send_exp(input logic f, input bit s, input logic [31:0] av,
                          input logic [31:0] bv, input res_t e);
    ovr    = e;
    ovr_en = 1;
    cycle(1, f, s, av, bv, e.tag, 1);
    drain();
  endtask

  function automatic logic [31:0] gen_b(input logic [31:0] av);
    logic [31:0] r;
    case ($urandom_range(0, 4))
      0:       r = av;
      1:       r = $urandom;
      2:       r = av ^ ($urandom & 32'h01C0_01C0);
      3:       r = $urandom & 32'h807F_807F;
      default: r = $urandom | 32'h7F80_7F80;
    endcase
    return r;
  endfunction

  initial begin
    int acc;
    logic [31:0] ra;
    rst       = 1'b1;
    in_valid  = 1'b0;
    fmt       = FP32;
    op_sub    = 1'b0;
    a         = '0;
    b         = '0;
    tag       = '0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    checks++;
    assert (out_valid === 1'b0 && observe() === '0) else begin
      errors++;
      $error("FAIL reset_outputs got=%b/%h want=0/0", out_valid, observe());
    end
    checks++;
    assert (in_ready === 1'b1) else begin
      errors++;
      $error("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    rst = 1'b0;

    // Directed vectors with hand-derived results.
    lat_chk = 1;
    send_exp(1'b0, 0, 32'h4040_0000, 32'h3F80_0000,
             '{fmt:1'b0, x_small:24'h800000, shamt:8'h01, big_frac:24'hC00000, big_exp:16'h0080,
               big_sign:2'b00, eff_sub:2'b00, swapped:2'b00, special:2'b00, tag:4'h1});
    send_exp(1'b0, 1, 32'h3F80_0000, 32'h4040_0000,
             '{fmt:1'b0, x_small:24'h800000, shamt:8'h01, big_frac:24'hC00000, big_exp:16'h0080,
               big_sign:2'b01, eff_sub:2'b01, swapped:2'b01, special:2'b00, tag:4'h2});
    send_exp(1'b0, 0, 32'h7F00_0000, 32'h3F80_0000,
             '{fmt:1'b0, x_small:24'h800000, shamt:8'h1F, big_frac:24'h800000, big_exp:16'h00FE,
               big_sign:2'b00, eff_sub:2'b00, swapped:2'b00, special:2'b00, tag:4'h3});
    send_exp(1'b0, 0, 32'h0040_0000, 32'h3F80_0000,
             '{fmt:1'b0, x_small:24'h000000, shamt:8'h1F, big_frac:24'h800000, big_exp:16'h007F,
               big_sign:2'b00, eff_sub:2'b00, swapped:2'b01, special:2'b00, tag:4'h4});
    send_exp(1'b1, 0, 32'h4040_3F80, 32'h3F80_4000,
             '{fmt:1'b1, x_small:24'h800080, shamt:8'h11, big_frac:24'hC00080, big_exp:16'h8080,
               big_sign:2'b00, eff_sub:2'b00, swapped:2'b01, special:2'b00, tag:4'h5});
    send_exp(1'b0, 1, 32'h4000_0000, 32'h4000_0000,
             '{fmt:1'b0, x_small:24'h800000, shamt:8'h00, big_frac:24'h800000, big_exp:16'h0080,
               big_sign:2'b00, eff_sub:2'b01, swapped:2'b00, special:2'b00, tag:4'h6});
    send_exp(1'b0, 0, 32'h7F80_0000, 32'h3F80_0000,
             '{fmt:1'b0, x_small:24'h800000, shamt:8'h1F, big_frac:24'h800000, big_exp:16'h00FF,
               big_sign:2'b00, eff_sub:2'b00, swapped:2'b00, special:2'b01, tag:4'h7});
    lat_chk = 0;

    // Backpressure: third back-to-back op must be refused while the consumer stalls.
    acc = 0;
    cycle(1, 1'b0, 0, 32'h4040_0000, 32'h3F80_0000, 4'h8, 0); acc += int'(last_acc);
    cycle(1, 1'b1, 1, 32'h4040_3F80, 32'h3F80_4000, 4'h9, 0); acc += int'(last_acc);
    cycle(1, 1'b0, 1, 32'h3F80_0000, 32'h4040_0000, 4'hA, 0); acc += int'(last_acc);
    cycle(1, 1'b0, 1, 32'h3F80_0000, 32'h4040_0000, 4'hA, 0); acc += int'(last_acc);
    checks++;
    assert (acc == 2 && in_ready === 1'b0) else begin
      errors++;
      $error("FAIL backpressure_accepts got=%0d/%b want=2/0", acc, in_ready);
    end
    cycle(1, 1'b0, 1, 32'h3F80_0000, 32'h4040_0000, 4'hA, 1);
    drain();

    // Asynchronous reset with both stages occupied.
    cycle(1, 1'b0, 0, 32'h4040_0000, 32'h3F80_0000, 4'hB, 0);
    cycle(1, 1'b1, 0, 32'h4040_3F80, 32'h3F80_4000, 4'hC, 0);
    cycle(0, 1'b0, 0, 32'h0, 32'h0, 4'h0, 0);
    #1 rst = 1'b1;
    #1;
    checks++;
    assert (out_valid === 1'b0 && observe() === '0) else begin
      errors++;
      $error("FAIL async_reset got=%b/%h want=0/0", out_valid, observe());
    end
    checks++;
    assert (in_ready === 1'b1) else begin
      errors++;
      $error("FAIL async_reset_in_ready got=%b want=1", in_ready);
    end
    #1 rst = 1'b0;
    q.delete();
    cyc_q.delete();
    occ        = 0;
    prev_stall = 0;
    cycle(1, 1'b0, 1, 32'h3F80_0000, 32'h4040_0000, 4'hD, 1);
    drain();

    // Randomized traffic with random consumer stalls.
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ra, gen_b(ra), 4'($urandom_range(0, 15)), $urandom_range(0, 9) < 7);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
